// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset control path: opcodes, ALU operation
// codes, immediate-format and write-back select encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // aluop: how the ALU decoder should interpret funct3/funct7
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU decoder: maps aluop plus funct3/funct7[5] to an ALU operation code.
// Only register-register ops (op5=1) may select subtract via funct7[5].
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] o_alucrtl
);

  always_comb begin
    o_alucrtl = ADD;
    case (aluop)
      ALUOP_ADD: o_alucrtl = ADD;
      ALUOP_SUB: o_alucrtl = SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  o_alucrtl = (op5 && funct7b5) ? SUB : ADD;
          3'b010:  o_alucrtl = SLT;
          3'b110:  o_alucrtl = OR;
          3'b111:  o_alucrtl = AND;
          default: o_alucrtl = ADD;
        endcase
      end
      default: o_alucrtl = ADD;
    endcase
  end

endmodule

// File: rtl/rv_controller.sv
// Single-cycle RV32I-subset controller: combinational main/ALU decode and a
// sticky illegal-opcode flag. Optional bne support under macro CTRL_BNE_EN.
module rv_controller
  import rv_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic [2:0] o_alucrtl,
  output logic [1:0] o_resultsrc,
  output logic [1:0] o_immsrc,
  output logic       o_memwrite,
  output logic       o_pcsrc,
  output logic       o_alusrc,
  output logic       o_regwrite,
  output logic       o_jump,
  output logic       o_illegal
);

  logic       branch;
  logic       take_branch;
  logic [1:0] aluop;
  logic       illegal_q;

  always_comb begin
    o_regwrite  = 1'b0;
    o_immsrc    = IMM_I;
    o_alusrc    = 1'b0;
    o_memwrite  = 1'b0;
    o_resultsrc = RES_ALU;
    branch      = 1'b0;
    aluop       = ALUOP_ADD;
    o_jump      = 1'b0;
    case (i_op)
      OP_LOAD: begin
        o_regwrite  = 1'b1;
        o_alusrc    = 1'b1;
        o_resultsrc = RES_MEM;
      end
      OP_STORE: begin
        o_immsrc   = IMM_S;
        o_alusrc   = 1'b1;
        o_memwrite = 1'b1;
      end
      OP_RTYPE: begin
        o_regwrite = 1'b1;
        aluop      = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        o_immsrc = IMM_B;
        branch   = 1'b1;
        aluop    = ALUOP_SUB;
      end
      OP_ITYPE: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        aluop      = ALUOP_FUNCT;
      end
      OP_JAL: begin
        o_regwrite  = 1'b1;
        o_immsrc    = IMM_J;
        o_resultsrc = RES_PC4;
        o_jump      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_BNE_EN
  // funct3 001 is bne; every other branch funct3 behaves as beq
  assign take_branch = (i_funct3 == 3'b001) ? ~i_zero : i_zero;
`else
  assign take_branch = i_zero;
`endif

  assign o_pcsrc = (branch & take_branch) | o_jump;

  rv_alu_decoder u_alu_dec (
    .aluop     (aluop),
    .funct3    (i_funct3),
    .op5       (i_op[5]),
    .funct7b5  (i_funct7b5),
    .o_alucrtl (o_alucrtl)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_q <= 1'b0;
    end else if (!is_supported(i_op)) begin
      illegal_q <= 1'b1;
    end
  end

  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_rv_controller.sv
// Scoreboard bench for rv_controller: stimulus pushes expected decode results
// from a mnemonic-level reference model; a negedge monitor pops and compares.
module tb_rv_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] alucrtl;
  logic [1:0] resultsrc;
  logic [1:0] immsrc;
  logic       memwrite;
  logic       pcsrc;
  logic       alusrc;
  logic       regwrite;
  logic       jump;
  logic       illegal;

  typedef struct packed {
    logic [2:0] alucrtl;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic       memwrite;
    logic       pcsrc;
    logic       alusrc;
    logic       regwrite;
    logic       jump;
    logic       illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic sticky;

  rv_controller dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op        (op),
    .i_funct3    (funct3),
    .i_funct7b5  (funct7b5),
    .i_zero      (zero),
    .o_alucrtl   (alucrtl),
    .o_resultsrc (resultsrc),
    .o_immsrc    (immsrc),
    .o_memwrite  (memwrite),
    .o_pcsrc     (pcsrc),
    .o_alusrc    (alusrc),
    .o_regwrite  (regwrite),
    .o_jump      (jump),
    .o_illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Arithmetic-type instructions: add/sub/slt/or/and by funct3
  function automatic logic [2:0] arith_op(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'd0:    return is_sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic ill);
    exp_t e;
    e = '0;
    e.illegal = ill;
    if (o == 7'b0000011) begin          // lw
      e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'd1;
    end else if (o == 7'b0100011) begin // sw
      e.immsrc = 2'd1; e.alusrc = 1; e.memwrite = 1;
    end else if (o == 7'b0110011) begin // R-type
      e.regwrite = 1; e.alucrtl = arith_op(f3, f7);
    end else if (o == 7'b0010011) begin // I-ALU: never subtracts
      e.regwrite = 1; e.alusrc = 1; e.alucrtl = arith_op(f3, 1'b0);
    end else if (o == 7'b1100011) begin // beq (bne when enabled)
      e.immsrc = 2'd2; e.alucrtl = 3'd1; e.pcsrc = z;
`ifdef CTRL_BNE_EN
      if (f3 == 3'd1) e.pcsrc = ~z;
`endif
    end else if (o == 7'b1101111) begin // jal
      e.regwrite = 1; e.immsrc = 2'd3; e.resultsrc = 2'd2; e.pcsrc = 1; e.jump = 1;
    end
    return e;
  endfunction

  // One vector per cycle; the op held across this edge feeds the sticky model.
  task automatic apply(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
    @(posedge clk);
    #1;
    if (!legal(op)) sticky = 1'b1;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    exp_q.push_back(model(o, f3, f7, z, sticky));
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results never compared, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{alucrtl, resultsrc, immsrc, memwrite, pcsrc, alusrc, regwrite, jump, illegal};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL decode op=%b f3=%b f7b5=%b zero=%b: got alu=%b res=%b imm=%b mw=%b pc=%b as=%b rw=%b j=%b ill=%b, required alu=%b res=%b imm=%b mw=%b pc=%b as=%b rw=%b j=%b ill=%b",
                 op, funct3, funct7b5, zero,
                 a.alucrtl, a.resultsrc, a.immsrc, a.memwrite, a.pcsrc, a.alusrc, a.regwrite, a.jump, a.illegal,
                 e.alucrtl, e.resultsrc, e.immsrc, e.memwrite, e.pcsrc, e.alusrc, e.regwrite, e.jump, e.illegal);
      end
    end
  end

  task automatic check_illegal(input string name, input logic req);
    n_cmp++;
    if (illegal !== req) begin
      n_err++;
      $display("FAIL %s: o_illegal got %b, required %b", name, illegal, req);
    end
  endtask

  logic [6:0] legal_ops[6];

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    rst_n = 1'b0;
    op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    sticky = 1'b0;
    #12;
    check_illegal("reset_state", 1'b0);
    #5 rst_n = 1'b1;

    apply(7'b0000011, 3'd2, 1'b0, 1'b0);   // lw
    apply(7'b0100011, 3'd2, 1'b0, 1'b0);   // sw
    apply(7'b0110011, 3'd0, 1'b0, 1'b0);   // add
    apply(7'b0110011, 3'd0, 1'b1, 1'b0);   // sub
    apply(7'b0110011, 3'd6, 1'b0, 1'b1);   // or
    apply(7'b0110011, 3'd7, 1'b0, 1'b0);   // and
    apply(7'b0110011, 3'd2, 1'b0, 1'b0);   // slt
    apply(7'b1100011, 3'd0, 1'b0, 1'b1);   // beq taken
    apply(7'b1100011, 3'd0, 1'b0, 1'b0);   // beq not taken
    apply(7'b1100011, 3'd1, 1'b0, 1'b1);   // funct3 001 under branch
    apply(7'b1100011, 3'd1, 1'b0, 1'b0);
    apply(7'b0010011, 3'd0, 1'b1, 1'b0);   // addi with instr[30]=1
    apply(7'b1101111, 3'd0, 1'b0, 1'b0);   // jal
    apply(7'b1111111, 3'd0, 1'b0, 1'b1);   // illegal, flag not yet set
    apply(7'b0000011, 3'd2, 1'b0, 1'b0);   // flag now set
    apply(7'b0110011, 3'd0, 1'b0, 1'b0);
    apply(7'b0100011, 3'd2, 1'b0, 1'b0);
    drain();

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_illegal("async_clear", 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    sticky = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      o = (sel < 6) ? legal_ops[sel] : 7'($urandom);
      apply(o, 3'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
